// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL/DIVU/REMU sequencer that borrows the EX-stage ALU.
// Shift-add multiply and restoring divide, each step issued as an ALU ADD/SUB/SLT.
module alu_muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             kill,
  input  logic [WIDTH-1:0] pipe_in1,
  input  logic [WIDTH-1:0] pipe_in2,
  input  logic [3:0]       pipe_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [3:0] CTRL_ADD = 4'h0;
  localparam logic [3:0] CTRL_SUB = 4'h1;
  localparam logic [3:0] CTRL_SLT = 4'h9;

  localparam logic [1:0] OP_DIVU = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_STEP,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             lt_q, lt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] cand;

  // Partial remainder with the next dividend bit shifted in.
  assign cand = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

  always_comb begin
    // NOTE: every _d gets a default here so no path leaves a latch behind.
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    quo_d    = quo_q;
    lt_d     = lt_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d    = op;
          count_d = '0;
          if (op[1]) begin
            rem_d   = '0;
            dvd_d   = rs1;
            dsr_d   = rs2;
            quo_d   = '0;
            state_d = S_DIV_CMP;
            if (DIV0_FAST && (rs2 == '0)) begin
              quo_d   = '1;
              rem_d   = rs1;
              state_d = S_DONE;
            end
          end else begin
            acc_d    = '0;
            mcand_d  = rs1;
            mplier_d = rs2;
            state_d  = S_MUL_STEP;
          end
        end
      end
      S_MUL_STEP: begin
        acc_d    = alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (count_q == 5'd31) state_d = S_DONE;
      end
      S_DIV_CMP: begin
        // A set top bit means cand overflowed 32 bits, so it cannot be below dsr.
        lt_d    = rem_q[WIDTH-1] ? 1'b0 : alu_out[0];
        rem_d   = cand;
        dvd_d   = dvd_q << 1;
        state_d = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        if (!lt_q) rem_d = alu_out;
        quo_d   = {quo_q[WIDTH-2:0], ~lt_q};
        count_d = count_q + 5'd1;
        state_d = (count_q == 5'd31) ? S_DONE : S_DIV_CMP;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result and done are registered on entry to DONE so both are glitch-free.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      done_d = 1'b1;
      case (op_d)
        OP_DIVU: result_d = quo_d;
        OP_REMU: result_d = rem_d;
        default: result_d = acc_d;
      endcase
    end

    if (kill) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: there is no memory here, so clearing every register on reset is cheap and keeps state fully defined.
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      quo_q    <= '0;
      lt_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      quo_q    <= quo_d;
      lt_q     <= lt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // ALU input arbiter: the pipeline owns the ALU except while a step is in flight.
  always_comb begin
    alu_in1  = pipe_in1;
    alu_in2  = pipe_in2;
    alu_ctrl = pipe_ctrl;
    case (state_q)
      S_MUL_STEP: begin
        alu_ctrl = CTRL_ADD;
        alu_in1  = acc_q;
        alu_in2  = mplier_q[0] ? mcand_q : '0;
      end
      S_DIV_CMP: begin
        alu_ctrl = CTRL_SLT;
        alu_in1  = cand;
        alu_in2  = dsr_q;
      end
      S_DIV_SUB: begin
        alu_ctrl = CTRL_SUB;
        alu_in1  = rem_q;
        alu_in2  = dsr_q;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q == S_MUL_STEP) || (state_q == S_DIV_CMP) || (state_q == S_DIV_SUB);
  assign stall  = busy || ((state_q == S_IDLE) && start && !kill);
  assign done   = done_q;
  assign result = result_q;

endmodule
